// File: rtl/fetch_pc_if.sv
// fetch_pc_if: fetch PC unit redirect/RAS request bundle and PC/status outputs
// master drives the i_* requests and observes o_*; slave is the PC unit side.
interface fetch_pc_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int RAS_DEPTH  = 4
);
  logic                        i_freeze;
  logic                        i_flush_valid;
  logic [ADDR_WIDTH-1:0]       i_flush_target;
  logic                        i_branch_valid;
  logic [ADDR_WIDTH-1:0]       i_branch_target;
  logic                        i_call_push;
  logic                        i_ret_pop;
  logic [ADDR_WIDTH-1:0]       o_pc;
  logic                        o_pc_redirected;
  logic                        o_pending_valid;
  logic [$clog2(RAS_DEPTH):0]  o_ras_count;
  logic                        o_ras_underflow;
  modport master (
    output i_freeze, i_flush_valid, i_flush_target, i_branch_valid, i_branch_target, i_call_push, i_ret_pop,
    input  o_pc, o_pc_redirected, o_pending_valid, o_ras_count, o_ras_underflow
  );
  modport slave (
    input  i_freeze, i_flush_valid, i_flush_target, i_branch_valid, i_branch_target, i_call_push, i_ret_pop,
    output o_pc, o_pc_redirected, o_pending_valid, o_ras_count, o_ras_underflow
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: fetch-stage PC with prioritised redirects, freeze capture and a circular RAS
// Ports: clk, reset (async, active-high), bus (fetch_pc_if.slave: redirect/RAS requests in, PC/status out).
module fetch_pc_unit #(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                    INC          = 4,
  parameter int                    RAS_DEPTH    = 4
) (
  input logic       clk,
  input logic       reset,
  fetch_pc_if.slave bus
);
  localparam int PW = $clog2(RAS_DEPTH);
  logic [ADDR_WIDTH-1:0] r_pc, r_pend_tgt, w_seq, w_next;
  logic [ADDR_WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]         r_ptr, w_ptr_up;
  logic [PW:0]           r_cnt;
  logic r_red, r_pend, r_pend_flush, r_under;
  logic w_run, w_br, w_pop, w_under, w_push;
  // w_run: normal cycle, no flush and no captured redirect being consumed
  always_comb begin
    w_seq    = r_pc + ADDR_WIDTH'(INC);
    w_ptr_up = r_ptr + 1'b1;
    w_run    = !bus.i_freeze && !bus.i_flush_valid && !r_pend;
    w_br     = w_run && bus.i_branch_valid;
    w_pop    = w_run && !bus.i_branch_valid && bus.i_ret_pop && r_cnt != '0;
    w_under  = w_run && !bus.i_branch_valid && bus.i_ret_pop && r_cnt == '0;
    w_push   = w_run && bus.i_call_push;
    w_next   = bus.i_flush_valid ? bus.i_flush_target :
               r_pend            ? r_pend_tgt :
               w_br              ? bus.i_branch_target :
               w_pop             ? r_ras[r_ptr] : w_seq;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_VECTOR;
      r_red        <= 1'b0;
      r_pend       <= 1'b0;
      r_pend_flush <= 1'b0;
      r_pend_tgt   <= '0;
      r_under      <= 1'b0;
      r_ptr        <= '0;
      r_cnt        <= '0;
    end else if (bus.i_freeze) begin
      r_under <= 1'b0;
      if (bus.i_flush_valid) begin
        r_pend       <= 1'b1;
        r_pend_flush <= 1'b1;
        r_pend_tgt   <= bus.i_flush_target;
      end else if (bus.i_branch_valid && !(r_pend && r_pend_flush)) begin
        r_pend       <= 1'b1;
        r_pend_flush <= 1'b0;
        r_pend_tgt   <= bus.i_branch_target;
      end
    end else begin
      r_pc         <= w_next;
      r_red        <= bus.i_flush_valid || r_pend || w_br || w_pop;
      r_pend       <= 1'b0;
      r_pend_flush <= 1'b0;
      r_under      <= w_under;
      r_ptr        <= (w_push && !w_pop) ? w_ptr_up : (w_pop && !w_push) ? r_ptr - 1'b1 : r_ptr;
      r_cnt        <= (w_push && !w_pop) ? ((r_cnt == (PW+1)'(RAS_DEPTH)) ? r_cnt : r_cnt + 1'b1) :
                      (w_pop && !w_push) ? r_cnt - 1'b1 : r_cnt;
    end
  end
  // push+pop replaces the old top in place; a plain push goes one above it
  always_ff @(posedge clk) begin
    if (w_push) r_ras[w_pop ? r_ptr : w_ptr_up] <= w_seq;
  end
  assign bus.o_pc            = r_pc;
  assign bus.o_pc_redirected = r_red;
  assign bus.o_pending_valid = r_pend;
  assign bus.o_ras_count     = r_cnt;
  assign bus.o_ras_underflow = r_under;
endmodule

// File: tb/tb_fetch_pc_unit.sv
// tb_fetch_pc_unit: scoreboard bench for fetch_pc_unit (32-bit main instance, 8-bit wrap instance)
module tb_fetch_pc_unit;
  typedef struct packed {
    logic [31:0] pc;
    logic        red;
    logic        pend;
    logic [2:0]  cnt;
    logic        und;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic r8 = 1'b1;
  int checks = 0;
  int failures = 0;
  int n = 0;
  exp_t q[$];
  fetch_pc_if #(.ADDR_WIDTH(32), .RAS_DEPTH(4)) bus ();
  fetch_pc_if #(.ADDR_WIDTH(8), .RAS_DEPTH(4)) b8 ();
  fetch_pc_unit #(.ADDR_WIDTH(32), .RESET_VECTOR(32'h0), .INC(4), .RAS_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  fetch_pc_unit #(.ADDR_WIDTH(8), .RESET_VECTOR(8'h0), .INC(4), .RAS_DEPTH(4)) dut8 (
    .clk(clk), .reset(r8), .bus(b8)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic idle();
    bus.i_freeze = 0; bus.i_flush_valid = 0; bus.i_flush_target = '0;
    bus.i_branch_valid = 0; bus.i_branch_target = '0; bus.i_call_push = 0; bus.i_ret_pop = 0;
  endtask
  // expectation is queued with the stimulus and retired after the edge
  task automatic cyc(input logic [31:0] pc, input logic red, input logic pend, input logic [2:0] cnt, input logic und);
    exp_t e;
    q.push_back('{pc: pc, red: red, pend: pend, cnt: cnt, und: und});
    @(posedge clk);
    #1;
    e = q.pop_front();
    n++;
    chk($sformatf("c%0d.pc", n), bus.o_pc, e.pc);
    chk($sformatf("c%0d.redir", n), 32'(bus.o_pc_redirected), 32'(e.red));
    chk($sformatf("c%0d.pend", n), 32'(bus.o_pending_valid), 32'(e.pend));
    chk($sformatf("c%0d.cnt", n), 32'(bus.o_ras_count), 32'(e.cnt));
    chk($sformatf("c%0d.under", n), 32'(bus.o_ras_underflow), 32'(e.und));
    idle();
  endtask
  initial begin
    idle();
    b8.i_freeze = 0; b8.i_flush_valid = 0; b8.i_flush_target = '0;
    b8.i_branch_valid = 0; b8.i_branch_target = '0; b8.i_call_push = 0; b8.i_ret_pop = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.pc", bus.o_pc, 32'h0);
    chk("rst.redir", 32'(bus.o_pc_redirected), 0);
    chk("rst.pend", 32'(bus.o_pending_valid), 0);
    chk("rst.cnt", 32'(bus.o_ras_count), 0);
    chk("rst.under", 32'(bus.o_ras_underflow), 0);
    @(negedge clk);
    reset = 0;
    @(posedge clk);
    #1;
    n = 0;
    q.push_back('{pc: 32'h4, red: 0, pend: 0, cnt: 0, und: 0});
    begin
      exp_t e;
      e = q.pop_front();
      chk("free1.pc", bus.o_pc, e.pc);
      chk("free1.redir", 32'(bus.o_pc_redirected), 32'(e.red));
    end
    cyc(32'h8, 0, 0, 0, 0);
    cyc(32'hC, 0, 0, 0, 0);
    cyc(32'h10, 0, 0, 0, 0);
    bus.i_branch_valid = 1; bus.i_branch_target = 32'h100;
    bus.i_flush_valid = 1; bus.i_flush_target = 32'h200;
    cyc(32'h200, 1, 0, 0, 0);
    bus.i_freeze = 1; bus.i_branch_valid = 1; bus.i_branch_target = 32'h40;
    cyc(32'h200, 1, 1, 0, 0);
    bus.i_freeze = 1; bus.i_flush_valid = 1; bus.i_flush_target = 32'h80;
    cyc(32'h200, 1, 1, 0, 0);
    bus.i_freeze = 1; bus.i_branch_valid = 1; bus.i_branch_target = 32'h60; bus.i_call_push = 1;
    cyc(32'h200, 1, 1, 0, 0);
    bus.i_branch_valid = 1; bus.i_branch_target = 32'h100; bus.i_ret_pop = 1; bus.i_call_push = 1;
    cyc(32'h80, 1, 0, 0, 0);
    cyc(32'h84, 0, 0, 0, 0);
    bus.i_flush_valid = 1; bus.i_flush_target = 32'h0;
    cyc(32'h0, 1, 0, 0, 0);
    for (int i = 1; i <= 5; i++) begin
      bus.i_call_push = 1;
      cyc(32'(4 * i), 0, 0, 3'((i > 4) ? 4 : i), 0);
    end
    for (int i = 0; i < 4; i++) begin
      bus.i_ret_pop = 1;
      cyc(32'h14 - 32'(4 * i), 1, 0, 3'(3 - i), 0);
    end
    bus.i_call_push = 1;
    cyc(32'hC, 0, 0, 1, 0);
    bus.i_call_push = 1; bus.i_ret_pop = 1;
    cyc(32'hC, 1, 0, 1, 0);
    bus.i_branch_valid = 1; bus.i_branch_target = 32'h300; bus.i_ret_pop = 1;
    cyc(32'h300, 1, 0, 1, 0);
    bus.i_ret_pop = 1;
    cyc(32'h10, 1, 0, 0, 0);
    bus.i_flush_valid = 1; bus.i_flush_target = 32'h20;
    cyc(32'h20, 1, 0, 0, 0);
    bus.i_ret_pop = 1;
    cyc(32'h24, 0, 0, 0, 1);
    cyc(32'h28, 0, 0, 0, 0);
    bus.i_freeze = 1; bus.i_call_push = 1; bus.i_ret_pop = 1;
    cyc(32'h28, 0, 0, 0, 0);
    bus.i_call_push = 1;
    cyc(32'h2C, 0, 0, 1, 0);
    bus.i_freeze = 1; bus.i_branch_valid = 1; bus.i_branch_target = 32'h500;
    cyc(32'h2C, 0, 1, 1, 0);
    bus.i_freeze = 1; bus.i_branch_valid = 1; bus.i_branch_target = 32'h500;
    #2;
    reset = 1;
    #1;
    chk("arst.pc", bus.o_pc, 32'h0);
    chk("arst.pend", 32'(bus.o_pending_valid), 0);
    chk("arst.cnt", 32'(bus.o_ras_count), 0);
    idle();
    @(negedge clk);
    reset = 0;
    cyc(32'h4, 0, 0, 0, 0);
    r8 = 0;
    @(posedge clk);
    repeat (62) @(posedge clk);
    #1;
    chk("w8.fc", 32'(b8.o_pc), 32'hFC);
    @(posedge clk);
    #1;
    chk("w8.wrap", 32'(b8.o_pc), 32'h0);
    chk("w8.redir", 32'(b8.o_pc_redirected), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Parametrised program-counter unit for the fetch stage. It holds the PC and advances it by a fixed instruction size, and it accepts prioritised redirects (flush, branch, return). A redirect that arrives during a freeze is captured and applied when the freeze releases. A circular return-address stack (RAS) predicts return targets. It sits at the head of the fetch stage and drives the instruction-memory address.

## Interface
- ADDR_WIDTH, 32, PC and target width in bits
- RESET_VECTOR, 0, PC value after reset
- INC, 4, sequential increment in bytes
- RAS_DEPTH, 4, RAS entries; power of two, ≥2
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; clears all state
- freeze  in  1  hold PC; RAS push/pop ignored
- flush_valid  in  1  highest-priority redirect request
- flush_target  in  ADDR_WIDTH  flush destination
- branch_valid  in  1  branch/jump redirect request
- branch_target  in  ADDR_WIDTH  branch destination
- call_push  in  1  push pc+INC onto RAS
- ret_pop  in  1  redirect to RAS top and pop
- pc  out  ADDR_WIDTH  current PC (registered)
- pc_redirected  out  1  current pc came from a non-sequential source
- pending_valid  out  1  captured redirect awaiting unfreeze
- ras_count  out  $clog2(RAS_DEPTH)+1  valid RAS entries
- ras_underflow  out  1  one-cycle pulse: ret_pop with empty RAS

## Operation
- Reset values: pc=RESET_VECTOR; pc_redirected=0; pending_valid=0; ras_count=0; ras_underflow=0; RAS pointer=0. RAS data is don't-care.
- Not frozen, next-PC priority:
  1. flush_valid → flush_target
  2. pending_valid → pending target
  3. branch_valid → branch_target
  4. ret_pop with ras_count>0 → RAS top
  5. pc+INC
- pc_redirected is loaded as 1 for choices 1–4 and 0 for choice 5.
- Frozen: pc and pc_redirected hold.
  - flush_valid captures flush_target into pending and marks it as flush type.
  - Otherwise, branch_valid captures branch_target into pending, unless a flush-type pending already exists. A later branch overwrites an earlier pending branch.
  - ret_pop and call_push are ignored.
- Unfreeze: pending is consumed on the first non-frozen edge (pending_valid→0), even if a same-cycle flush wins. branch_valid and ret_pop are ignored on that cycle.
- RAS: push and pop act only when not frozen and no flush_valid or pending is being taken. A pop is applied only when ret_pop actually selects the next PC.
  - Push: writes pc+INC at top+1, pointer increments, ras_count saturates at RAS_DEPTH. On overflow the oldest entry is overwritten circularly.
  - Pop (count>0): redirect to top, pointer decrements, ras_count decrements.
  - Push and pop in the same cycle: redirect to the old top, then the top is replaced with pc+INC; ras_count unchanged.
  - ret_pop with ras_count=0: no redirect, sequential PC, ras_underflow=1 next cycle.
  - ret_pop suppressed by a higher-priority branch: no pop, no underflow.
- Arithmetic: pc+INC wraps modulo 2^ADDR_WIDTH. Targets are loaded unaligned, as given.

## Timing
- All outputs are registered. A redirect requested in cycle N appears on pc in cycle N+1.
- Freeze in cycle N: pc in N+1 equals pc in N.
- A pending redirect captured in frozen cycle N, with freeze low in cycle M, appears on pc in M+1.
- ras_underflow is high for exactly one cycle, following the offending edge.
- Reset asserted mid-operation takes effect immediately (asynchronous). Pending and RAS state are discarded. The first edge after release loads RESET_VECTOR+INC unless a redirect is requested.

## Test plan
- Reset, then 3 free cycles → pc = 0, 4, 8, C; pc_redirected=0 throughout.
- pc=0x10; branch_valid=1, target=0x100, with flush_valid=1, target=0x200, same cycle → pc=0x200, pc_redirected=1.
- Freeze for 3 cycles, branch 0x40 in cycle 1, then flush 0x80 in cycle 2 → pc held, pending_valid=1. After unfreeze: pc=0x80, pending_valid=0.
- RAS_DEPTH=4: 5 call_push from pc 0x0,0x4,..,0x10 (pushing 0x4..0x14) → ras_count=4. Then 4 ret_pop → pc = 0x14, 0x10, 0xC, 0x8; ras_count=0.
- ret_pop with empty RAS at pc=0x20 → pc=0x24, ras_underflow pulse of 1 cycle.
- ADDR_WIDTH=8, pc=0xFC → next pc=0x00. Reset asserted mid-freeze with pending → pc=RESET_VECTOR, pending_valid=0, ras_count=0 immediately.
